// File: rtl/wb_irq_timer.sv
// Wishbone B3 classic slave with a prescaled compare-match timer.
// The timer raises a level interrupt that the CPU sees on its irq vector.
module wb_irq_timer #(
    parameter int PRESC_W = 8,
    parameter int CNT_W   = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        irq_o
);

    logic               ack_q, ack_d;
    logic [31:0]        datOut_q, datOut_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   compare_q, compare_d;
    logic               enable_q, enable_d;
    logic               periodic_q, periodic_d;
    logic               irqEn_q, irqEn_d;
    logic [PRESC_W-1:0] div_q, div_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               pend_q, pend_d;

    logic        busReq, busWr;
    logic [1:0]  regSel;
    logic [31:0] ctrlWord, readData, wrWord;
    logic        wrCount, wrCompare, wrCtrl, wrStatus;
    logic        tick, match;
    logic        unusedAdrBits;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  byteSel);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = byteSel[b] ? newWord[8*b +: 8] : oldWord[8*b +: 8];
        end
        return merged;
    endfunction

    assign busReq        = wb_cyc_i & wb_stb_i & ~ack_q;
    assign busWr         = busReq & wb_we_i;
    assign regSel        = wb_adr_i[3:2];
    assign unusedAdrBits = &{1'b0, wb_adr_i[1:0]};

    always_comb begin
        ctrlWord                 = '0;
        ctrlWord[0]              = enable_q;
        ctrlWord[1]              = periodic_q;
        ctrlWord[2]              = irqEn_q;
        ctrlWord[8 +: PRESC_W]   = div_q;
    end

    always_comb begin
        readData = '0;
        case (regSel)
            2'd0:    readData = 32'(count_q);
            2'd1:    readData = 32'(compare_q);
            2'd2:    readData = ctrlWord;
            default: readData = {31'b0, pend_q};
        endcase
    end

    // Partial byte writes merge into the register's current contents.
    assign wrWord    = mergeBytes(readData, wb_dat_i, wb_sel_i);
    assign wrCount   = busWr && (regSel == 2'd0);
    assign wrCompare = busWr && (regSel == 2'd1);
    assign wrCtrl    = busWr && (regSel == 2'd2);
    assign wrStatus  = busWr && (regSel == 2'd3);

    assign tick  = enable_q && (presc_q == div_q);
    assign match = (count_q == compare_q);

    always_comb begin
        ack_d      = busReq;
        datOut_d   = busReq ? readData : datOut_q;
        presc_d    = (!enable_q || tick) ? '0 : presc_q + 1'b1;
        count_d    = count_q;
        compare_d  = compare_q;
        enable_d   = enable_q;
        periodic_d = periodic_q;
        irqEn_d    = irqEn_q;
        div_d      = div_q;
        pend_d     = pend_q;

        // A software write to COUNT or CTRL overrides what the tick would do there.
        if (tick && !(wrCount || wrCtrl)) begin
            if (match) begin
                if (periodic_q) begin
                    count_d = '0;
                end else begin
                    enable_d = 1'b0;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        if (wrCount) begin
            count_d = wrWord[CNT_W-1:0];
        end
        if (wrCompare) begin
            compare_d = wrWord[CNT_W-1:0];
        end
        if (wrCtrl) begin
            enable_d   = wrWord[0];
            periodic_d = wrWord[1];
            irqEn_d    = wrWord[2];
            div_d      = wrWord[8 +: PRESC_W];
        end

        if (wrStatus && wb_sel_i[0] && wb_dat_i[0]) begin
            pend_d = 1'b0;
        end
        if (tick && match) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            ack_q      <= 1'b0;
            datOut_q   <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            enable_q   <= 1'b0;
            periodic_q <= 1'b0;
            irqEn_q    <= 1'b0;
            div_q      <= '0;
            presc_q    <= '0;
            pend_q     <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            datOut_q   <= datOut_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            enable_q   <= enable_d;
            periodic_q <= periodic_d;
            irqEn_q    <= irqEn_d;
            div_q      <= div_d;
            presc_q    <= presc_d;
            pend_q     <= pend_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = datOut_q;
    assign wb_err_o = 1'b0;
    assign irq_o    = pend_q & irqEn_q;

endmodule

// File: tb/tb_wb_irq_timer.sv
// Directed bench for wb_irq_timer: a register vector table followed by
// hand-timed sequences for interrupt timing, collisions and reset.
module tb_wb_irq_timer;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [3:0]  adr = '0;
    logic [31:0] datIn = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] datOut;
    logic        ack;
    logic        err;
    logic        irq;

    logic [31:0] rd;
    int          numCompared = 0;
    int          numMismatched = 0;

    typedef struct {
        logic        isWrite;
        logic [3:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] expRead;
        string       name;
    } vector_t;

    vector_t vecs [17];

    wb_irq_timer #(.PRESC_W(8), .CNT_W(32)) dut (
        .wb_clk_i (clk),
        .wb_rstn_i(rstN),
        .wb_adr_i (adr),
        .wb_dat_i (datIn),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_dat_o (datOut),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered on a falling edge; the access lands on the next rising edge.
    task automatic applyStimulus(input logic isWrite, input logic [3:0] address,
                                 input logic [31:0] data, input logic [3:0] byteSel,
                                 output logic [31:0] readBack);
        we    = isWrite;
        adr   = address;
        datIn = data;
        sel   = byteSel;
        cyc   = 1'b1;
        stb   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("ack_rise", {31'b0, ack}, 32'd1);
        readBack = datOut;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        checkOutput("ack_pulse", {31'b0, ack}, 32'd0);
    endtask

    task automatic busWrite(input logic [3:0] address, input logic [31:0] data);
        logic [31:0] ignored;
        applyStimulus(1'b1, address, data, 4'hF, ignored);
    endtask

    task automatic busRead(input logic [3:0] address, output logic [31:0] data);
        applyStimulus(1'b0, address, 32'h0, 4'hF, data);
    endtask

    task automatic resetDut();
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h0,        "rst_count"};
        vecs[1]  = '{1'b0, 4'h5, 32'h0,        4'hF, 32'h0,        "rst_compare"};
        vecs[2]  = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h0,        "rst_ctrl"};
        vecs[3]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0,        "rst_status"};
        vecs[4]  = '{1'b1, 4'h4, 32'h12345678, 4'hF, 32'h0,        "wr_compare"};
        vecs[5]  = '{1'b0, 4'h7, 32'h0,        4'hF, 32'h12345678, "compare_rw"};
        vecs[6]  = '{1'b1, 4'h4, 32'h0,        4'hF, 32'h0,        "clr_compare"};
        vecs[7]  = '{1'b1, 4'h4, 32'hAABBCCDD, 4'h2, 32'h0,        "wr_compare_b1"};
        vecs[8]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h0000CC00, "compare_bytelane"};
        vecs[9]  = '{1'b1, 4'h8, 32'hFFFFFFFE, 4'hF, 32'h0,        "wr_ctrl"};
        vecs[10] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h0000FF06, "ctrl_fields"};
        vecs[11] = '{1'b1, 4'h8, 32'h0,        4'hF, 32'h0,        "clr_ctrl"};
        vecs[12] = '{1'b1, 4'h0, 32'hDEADBEEF, 4'hC, 32'h0,        "wr_count_hi"};
        vecs[13] = '{1'b0, 4'h0, 32'h0,        4'hF, 32'hDEAD0000, "count_bytelane"};
        vecs[14] = '{1'b1, 4'hC, 32'h1,        4'hF, 32'h0,        "w1c_idle"};
        vecs[15] = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0,        "status_idle"};
        vecs[16] = '{1'b1, 4'h0, 32'h0,        4'hF, 32'h0,        "clr_count"};

        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ack", {31'b0, ack}, 32'd0);
        checkOutput("reset_irq", {31'b0, irq}, 32'd0);
        checkOutput("reset_dat", datOut, 32'h0);
        checkOutput("reset_err", {31'b0, err}, 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].isWrite, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
            if (!vecs[i].isWrite) begin
                checkOutput(vecs[i].name, rd, vecs[i].expRead);
            end
        end

        // Held request: ack toggles 1,0,1,0.
        adr = 4'h4; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("b2b_ack", {31'b0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);

        // Strobe never raised: no ack and no write.
        adr = 4'h4; we = 1'b1; datIn = 32'h00001234; cyc = 1'b1; stb = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("nostb_ack", {31'b0, ack}, 32'd0);
        cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        busRead(4'h4, rd);
        checkOutput("nostb_compare", rd, 32'h0000CC00);

        // Periodic, div=0, compare 5.
        resetDut();
        busWrite(4'h4, 32'd5);
        busWrite(4'h8, 32'h7);
        waitCycles(4);
        checkOutput("per_irq_early", {31'b0, irq}, 32'd0);
        waitCycles(1);
        checkOutput("per_irq_rise", {31'b0, irq}, 32'd1);
        busRead(4'h0, rd);
        checkOutput("per_count_zero", rd, 32'h0);
        busWrite(4'hC, 32'h1);
        checkOutput("per_irq_cleared", {31'b0, irq}, 32'd0);
        waitCycles(1);
        checkOutput("per_irq_gap", {31'b0, irq}, 32'd0);
        waitCycles(1);
        checkOutput("per_irq_second", {31'b0, irq}, 32'd1);

        // One-shot, div=3, compare 2.
        resetDut();
        busWrite(4'h4, 32'd2);
        busWrite(4'h8, 32'h0305);
        waitCycles(10);
        checkOutput("os_irq_early", {31'b0, irq}, 32'd0);
        waitCycles(1);
        checkOutput("os_irq_rise", {31'b0, irq}, 32'd1);
        busRead(4'h8, rd);
        checkOutput("os_ctrl_en_off", rd, 32'h0304);
        busRead(4'h0, rd);
        checkOutput("os_count_hold", rd, 32'd2);
        waitCycles(4);
        busRead(4'h0, rd);
        checkOutput("os_count_still", rd, 32'd2);
        busWrite(4'hC, 32'h0);
        checkOutput("os_w0_noeffect", {31'b0, irq}, 32'd1);
        busWrite(4'hC, 32'h1);
        checkOutput("os_irq_cleared", {31'b0, irq}, 32'd0);

        // W1C lands on the match edge.
        resetDut();
        busWrite(4'h4, 32'd3);
        busWrite(4'h8, 32'h7);
        waitCycles(2);
        busWrite(4'hC, 32'h1);
        checkOutput("col_irq_kept", {31'b0, irq}, 32'd1);
        busRead(4'hC, rd);
        checkOutput("col_pend_kept", rd, 32'd1);

        // COUNT write on a tick edge (div=1, ticks every other edge).
        resetDut();
        busWrite(4'h4, 32'h0000FFFF);
        busWrite(4'h8, 32'h0101);
        busWrite(4'h0, 32'h100);
        busRead(4'h0, rd);
        checkOutput("col_count_sw", rd, 32'h100);
        busRead(4'h0, rd);
        checkOutput("col_count_next", rd, 32'h101);

        // Reset while a write ack is pending and the timer is running.
        resetDut();
        busWrite(4'h4, 32'h0);
        busWrite(4'h8, 32'h7);
        checkOutput("rst_pre_irq", {31'b0, irq}, 32'd1);
        we = 1'b1; adr = 4'h8; datIn = 32'h0503; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_inflight_ack", {31'b0, ack}, 32'd1);
        checkOutput("rst_inflight_dat", datOut, 32'h7);
        rstN = 1'b0;
        #1;
        checkOutput("rst_async_ack", {31'b0, ack}, 32'd0);
        checkOutput("rst_async_dat", datOut, 32'h0);
        checkOutput("rst_async_irq", {31'b0, irq}, 32'd0);
        checkOutput("rst_async_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        checkOutput("rst_held_ack", {31'b0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rstN = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            busRead(4'(r * 4), rd);
            checkOutput("rst_after_reg", rd, 32'h0);
        end
        waitCycles(3);
        checkOutput("rst_after_irq", {31'b0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
